// File: rtl/median_window_ctrl_if.sv
// median_window_ctrl_if
//   Pixel-in / median-out stream bundle for median_window_ctrl.
//   master : pixel source + median sink side (drives in_valid, in_pixel, out_ready)
//   slave  : the controller (drives in_ready, out_valid, out_pixel, out_last)
//   Signals:
//     in_valid/in_ready/in_pixel    raster-order input stream
//     out_valid/out_ready/out_pixel filtered output stream
//     out_last                      marks the final median of a frame
interface median_window_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pixel;
  logic              out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/median_window_ctrl.sv
// median_window_ctrl
//   Streams a raster image through two line buffers and a 3x3 window register,
//   presents each interior window to an external combinational median core and
//   returns the core result on a valid/ready stream with an end-of-frame flag.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     s (slave)         input pixel stream and output median stream
//     win_x1..win_x9    window to the median core, row-major, win_x9 newest
//     core_median       combinational median of win_x1..win_x9
module median_window_ctrl #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  median_window_ctrl_if.slave s,
  output logic [DATA_W-1:0] win_x1,
  output logic [DATA_W-1:0] win_x2,
  output logic [DATA_W-1:0] win_x3,
  output logic [DATA_W-1:0] win_x4,
  output logic [DATA_W-1:0] win_x5,
  output logic [DATA_W-1:0] win_x6,
  output logic [DATA_W-1:0] win_x7,
  output logic [DATA_W-1:0] win_x8,
  output logic [DATA_W-1:0] win_x9,
  input  logic [DATA_W-1:0] core_median
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     col_reg, col_next;
  logic [RW-1:0]     row_reg, row_next;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] win_reg [9];
  logic [DATA_W-1:0] col_new [3];
  logic              wv_reg, wlast_reg;
  logic              out_valid_reg, out_last_reg;
  logic [DATA_W-1:0] out_pixel_reg;
  logic              accept, advance, qualify, is_last;

  // Output slot can take a new value when empty or being drained this cycle.
  assign advance    = !out_valid_reg || s.out_ready;
  assign s.in_ready = !wv_reg || advance;
  assign accept     = s.in_valid && s.in_ready;
  assign qualify    = (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
  assign is_last    = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

  // Raster position counters.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_ONE;
      end else begin
        col_next = col_reg + COL_ONE;
      end
    end
  end

  // Line buffers are read asynchronously so the new window column is formed
  // in the same cycle as the accept. Contents are never cleared: rows 0-1
  // only ever feed windows that are not emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_reg] <= lb1[col_reg];
      lb1[col_reg] <= s.in_pixel;
    end
  end

  // New column, top to bottom: row-2, row-1, current row.
  assign col_new[0] = lb2[col_reg];
  assign col_new[1] = lb1[col_reg];
  assign col_new[2] = s.in_pixel;

  // Each window row is a 3-deep shift register fed by its column entry.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      always_ff @(posedge clk) begin
        if (rst) begin
          win_reg[3*gi]   <= '0;
          win_reg[3*gi+1] <= '0;
          win_reg[3*gi+2] <= '0;
        end else if (accept) begin
          win_reg[3*gi]   <= win_reg[3*gi+1];
          win_reg[3*gi+1] <= win_reg[3*gi+2];
          win_reg[3*gi+2] <= col_new[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg       <= '0;
      row_reg       <= '0;
      wv_reg        <= 1'b0;
      wlast_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_pixel_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
      // An accept while wv is set implies advance, so the window being
      // replaced has already been consumed by the output stage.
      if (accept) begin
        wv_reg    <= qualify;
        wlast_reg <= is_last;
      end else if (advance) begin
        wv_reg <= 1'b0;
      end
      if (advance) begin
        out_valid_reg <= wv_reg;
        out_last_reg  <= wv_reg && wlast_reg;
        if (wv_reg) begin
          out_pixel_reg <= core_median;
        end
      end
    end
  end

  assign s.out_valid = out_valid_reg;
  assign s.out_last  = out_last_reg;
  assign s.out_pixel = out_pixel_reg;

  assign win_x1 = win_reg[0];
  assign win_x2 = win_reg[1];
  assign win_x3 = win_reg[2];
  assign win_x4 = win_reg[3];
  assign win_x5 = win_reg[4];
  assign win_x6 = win_reg[5];
  assign win_x7 = win_reg[6];
  assign win_x8 = win_reg[7];
  assign win_x9 = win_reg[8];

endmodule

// File: tb/tb_median_window_ctrl.sv
// tb_median_window_ctrl
//   Drives 4x4 and 3x3 instances of median_window_ctrl with a behavioural
//   median core, and compares every output handshake against medians computed
//   directly from the source image neighbourhoods.
module tb_median_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_window_ctrl_if #(.DATA_W(8)) if4 ();
  median_window_ctrl_if #(.DATA_W(8)) if3 ();

  logic [7:0] w4 [9];
  logic [7:0] w3 [9];
  logic [7:0] core4, core3;

  function automatic logic [7:0] median9(input logic [7:0] v [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    a = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  always_comb core4 = median9(w4);
  always_comb core3 = median9(w3);

  median_window_ctrl #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut4 (
    .clk(clk), .rst(rst), .s(if4),
    .win_x1(w4[0]), .win_x2(w4[1]), .win_x3(w4[2]),
    .win_x4(w4[3]), .win_x5(w4[4]), .win_x6(w4[5]),
    .win_x7(w4[6]), .win_x8(w4[7]), .win_x9(w4[8]),
    .core_median(core4)
  );

  median_window_ctrl #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .s(if3),
    .win_x1(w3[0]), .win_x2(w3[1]), .win_x3(w3[2]),
    .win_x4(w3[3]), .win_x5(w3[4]), .win_x6(w3[5]),
    .win_x7(w3[6]), .win_x8(w3[7]), .win_x9(w3[8]),
    .core_median(core3)
  );

  int compare_cnt  = 0;
  int mismatch_cnt = 0;
  int cyc = 0;
  int or_mode = 0;
  int acc10_cyc = -100;
  int first_ov_cyc = -1;
  bit win_chk_en = 0;
  logic [7:0] img [W*H];
  int exp_q [$];

  task automatic chk(input string tag, input int obs, input int exp);
    compare_cnt++;
    if (obs != exp) begin
      mismatch_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: median of each interior 3x3 neighbourhood in raster order.
  task automatic push_expected();
    logic [7:0] v [9];
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        for (int k = 0; k < 9; k++)
          v[k] = img[(r - 1 + k / 3) * W + (c - 1 + k % 3)];
        exp_q.push_back(((r == H - 2 && c == W - 2) ? 256 : 0) + int'(median9(v)));
      end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sink back-pressure generator.
  initial begin
    int k;
    int pat [4];
    pat = '{1, 0, 0, 1};
    k = 0;
    if4.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: if4.out_ready = 1'b1;
        1: begin if4.out_ready = pat[k % 4] != 0; k++; end
        default: if4.out_ready = $urandom_range(0, 1) != 0;
      endcase
    end
  end

  // Output monitor for the 4x4 instance.
  initial begin
    bit hold_v;
    int hold_pix, hold_last, e;
    hold_v = 0; hold_pix = 0; hold_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 0;
      end else begin
        if (win_chk_en && cyc == acc10_cyc + 1) begin
          chk("win_x1", w4[0], 0);
          chk("win_x5", w4[4], 5);
          chk("win_x9", w4[8], 10);
        end
        if (hold_v) begin
          chk("stall_valid", if4.out_valid, 1);
          chk("stall_pix", if4.out_pixel, hold_pix);
          chk("stall_last", if4.out_last, hold_last);
        end
        if (!if4.out_valid) chk("last_idle", if4.out_last, 0);
        if (if4.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (if4.out_valid && if4.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_out", if4.out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pix", if4.out_pixel, e % 256);
            chk("last", if4.out_last, e / 256);
            $display("out pixel=%0d last=%0d exp=%0d/%0d", if4.out_pixel, if4.out_last, e % 256, e / 256);
          end
        end
        hold_v    = if4.out_valid && !if4.out_ready;
        hold_pix  = if4.out_pixel;
        hold_last = if4.out_last;
      end
    end
  end

  // 3x3 instance output counter.
  int n3 = 0;
  int pix3 = -1;
  int last3 = -1;
  initial forever begin
    @(negedge clk);
    if (!rst && if3.out_valid && if3.out_ready) begin
      n3++; pix3 = if3.out_pixel; last3 = if3.out_last;
    end
  end

  task automatic drive_frame(input int n_acc, input int gap, input bit rec10);
    int idx, budget;
    idx = 0; budget = 0;
    while (idx < n_acc && budget < 2000) begin
      @(posedge clk); #1;
      if4.in_valid = !(gap > 0 && $urandom_range(0, 99) < gap);
      if4.in_pixel = img[idx];
      @(negedge clk);
      if (if4.in_valid && if4.in_ready) begin
        if (rec10 && idx == 10) acc10_cyc = cyc;
        idx++;
      end
      budget++;
    end
    if (budget >= 2000) chk("drive_timeout", idx, n_acc);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      @(posedge clk);
      b++;
    end
    repeat (6) @(posedge clk);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, if4.in_ready, 1);
    chk({tag, "_out_valid"}, if4.out_valid, 0);
    chk({tag, "_out_last"}, if4.out_last, 0);
    chk({tag, "_out_pixel"}, if4.out_pixel, 0);
    chk({tag, "_win_x1"}, w4[0], 0);
    chk({tag, "_win_x9"}, w4[8], 0);
  endtask

  // Reset while presenting a pixel: the reset must win over the accept.
  task automatic pulse_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1; if4.in_valid = 1'b1; if4.in_pixel = 8'd99;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals({tag, "_during"});
    @(posedge clk); #1;
    rst = 1'b0; if4.in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals({tag, "_after"});
  endtask

  task automatic load_ramp();
    for (int i = 0; i < W * H; i++) img[i] = 8'(i);
  endtask

  initial begin
    logic [7:0] seq3 [9];
    int idx, budget;
    if4.in_valid = 1'b0; if4.in_pixel = '0;
    if3.in_valid = 1'b0; if3.in_pixel = '0; if3.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // Ramp, no back-pressure, latency and window contents.
    $display("test ramp_free");
    load_ramp(); push_expected();
    first_ov_cyc = -1; win_chk_en = 1;
    drive_frame(W * H, 0, 1'b1); go_idle(); drain("ramp_free_left");
    win_chk_en = 0;
    chk("latency", first_ov_cyc - acc10_cyc, 2);

    // Ramp with 1-0-0-1 sink and gapped source.
    $display("test ramp_stall");
    or_mode = 1; push_expected();
    drive_frame(W * H, 30, 1'b0); go_idle(); drain("ramp_stall_left");

    // Impulse is removed by the median.
    $display("test impulse");
    or_mode = 2;
    for (int i = 0; i < W * H; i++) img[i] = 8'd10;
    img[5] = 8'd255;
    push_expected();
    drive_frame(W * H, 20, 1'b0); go_idle(); drain("impulse_left");

    // Two frames back-to-back.
    $display("test back_to_back");
    or_mode = 0; load_ramp(); push_expected(); push_expected();
    drive_frame(W * H, 0, 1'b0); drive_frame(W * H, 0, 1'b0);
    go_idle(); drain("b2b_left");

    // Reset after 7 accepts, then a full frame.
    $display("test mid_reset");
    drive_frame(7, 0, 1'b0);
    pulse_reset("rst1");
    push_expected();
    drive_frame(W * H, 0, 1'b0); go_idle(); drain("mid_reset_left");

    // Random images under random flow control.
    for (int f = 0; f < 4; f++) begin
      $display("test random frame %0d", f);
      or_mode = 2;
      for (int i = 0; i < W * H; i++) img[i] = 8'($urandom_range(0, 255));
      push_expected();
      drive_frame(W * H, $urandom_range(0, 50), 1'b0); go_idle(); drain("random_left");
    end

    // 3x3 image: single output.
    $display("test img3x3");
    for (int i = 0; i < 9; i++) seq3[i] = 8'(9 - i);
    idx = 0; budget = 0;
    while (idx < 9 && budget < 100) begin
      @(posedge clk); #1;
      if3.in_valid = 1'b1; if3.in_pixel = seq3[idx];
      @(negedge clk);
      if (if3.in_ready) idx++;
      budget++;
    end
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    chk("x3_count", n3, 1);
    chk("x3_pixel", pix3, 5);
    chk("x3_last", last3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
